// File: rtl/onehot_index_decoder_pkg.sv
// Shared constants and state encoding for the one-hot index decoder.
// Imported by the interface and the decoder module.
package onehot_index_decoder_pkg;

  localparam int unsigned DEC_WIDTH = 32;
  localparam int unsigned DEC_IDX_W = 5;

  // Hit counter is 2 bits and stops at 2: "two or more bits set".
  localparam logic [1:0] HIT_SAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dec_state_e;

endpackage

// File: rtl/onehot_index_decoder_if.sv
// Valid/ready input and result channels of the one-hot index decoder.
// The master side is the upstream producer and result consumer.
interface onehot_index_decoder_if
  import onehot_index_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_WIDTH,
  parameter int unsigned IDX_W = DEC_IDX_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_err_zero;
  logic             out_err_multi;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_err_zero,
    input  out_err_multi
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_err_zero,
    output out_err_multi
  );

endinterface

// File: rtl/onehot_index_decoder.sv
// Sequential one-hot to binary index decoder: scans a captured vector MSB first,
// one bit per cycle, with fixed WIDTH-cycle latency and zero/multi-hot flags.
module onehot_index_decoder
  import onehot_index_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_WIDTH,
  parameter int unsigned IDX_W = DEC_IDX_W
) (
  input logic                  clk,
  input logic                  rst,
  onehot_index_decoder_if.slave bus
);

  if (IDX_W != $clog2(WIDTH)) begin : g_width_check
    $error("onehot_index_decoder: IDX_W must equal clog2(WIDTH)");
  end

  localparam logic [IDX_W-1:0] CNT_TOP = IDX_W'(WIDTH - 1);

  dec_state_e       state_q,     state_d;
  logic [IDX_W-1:0] cnt_q,       cnt_d;
  logic [1:0]       hit_q,       hit_d;
  logic [WIDTH-1:0] shadow_q,    shadow_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic             err_zero_q,  err_zero_d;
  logic             err_multi_q, err_multi_d;

  logic             scan_bit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    err_zero_d  = err_zero_q;
    err_multi_d = err_multi_q;
    scan_bit    = shadow_q[cnt_q];

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shadow_d = bus.in_vec;
          cnt_d    = CNT_TOP;
          hit_d    = '0;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        // First hit seen in MSB-first order is the encoder's priority winner.
        if (scan_bit && (hit_q == '0)) begin
          idx_d = cnt_q;
        end
        if (scan_bit && (hit_q != HIT_SAT)) begin
          hit_d = hit_q + 2'd1;
        end
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_idx_d   = idx_d;
          err_zero_d  = (hit_d == '0);
          err_multi_d = (hit_d >= HIT_SAT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_TOP;
      hit_q       <= '0;
      shadow_q    <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      err_zero_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      err_zero_q  <= err_zero_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_idx       = out_idx_q;
  assign bus.out_err_zero  = err_zero_q;
  assign bus.out_err_multi = err_multi_q;

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Directed, table-driven bench for onehot_index_decoder with hand-computed
// expectations plus backpressure and mid-scan reset sequences.
module tb_onehot_index_decoder;

  logic clk;
  logic rst;

  int unsigned passed;
  int unsigned total;

  onehot_index_decoder_if #(.WIDTH(32), .IDX_W(5)) bus ();

  onehot_index_decoder #(.WIDTH(32), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] vec;
    logic [4:0]  idx;
    logic        ez;
    logic        em;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, " ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_vec(input logic [31:0] vec, input logic [4:0] eidx,
                         input logic ez, input logic em, input string tag);
    int lat;
    wait_ready(tag);
    bus.in_vec    = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_vec   = ~vec;
    check({tag, " busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd32);
    check({tag, " idx"}, 32'(bus.out_idx), 32'(eidx));
    check({tag, " err_zero"}, 32'(bus.out_err_zero), 32'(ez));
    check({tag, " err_multi"}, 32'(bus.out_err_multi), 32'(em));
    tick();
    check({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " ready after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    passed = 0;
    total  = 0;

    for (int i = 0; i < 32; i++) begin
      tbl.push_back('{vec: 32'd1 << i, idx: 5'(i), ez: 1'b0, em: 1'b0});
    end
    tbl.push_back('{vec: 32'h0000_0400, idx: 5'd10, ez: 1'b0, em: 1'b0});
    tbl.push_back('{vec: 32'h8000_0001, idx: 5'd31, ez: 1'b0, em: 1'b1});
    tbl.push_back('{vec: 32'h0000_0003, idx: 5'd1,  ez: 1'b0, em: 1'b1});
    tbl.push_back('{vec: 32'h0000_0000, idx: 5'd0,  ez: 1'b1, em: 1'b0});
    tbl.push_back('{vec: 32'hFFFF_FFFF, idx: 5'd31, ez: 1'b0, em: 1'b1});
    tbl.push_back('{vec: 32'h0001_0100, idx: 5'd16, ez: 1'b0, em: 1'b1});

    // Reset held with an aggressive producer.
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 32'hFFFF_FFFF;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset%0d out_valid", c), 32'(bus.out_valid), 32'd0);
      check($sformatf("reset%0d out_idx", c), 32'(bus.out_idx), 32'd0);
      check($sformatf("reset%0d errs", c),
            32'({bus.out_err_zero, bus.out_err_multi}), 32'd0);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    check("reset release in_ready", 32'(bus.in_ready), 32'd1);

    foreach (tbl[k]) begin
      run_vec(tbl[k].vec, tbl[k].idx, tbl[k].ez, tbl[k].em, $sformatf("vec%0d", k));
    end

    // Backpressure: result held, no accept while stalled.
    wait_ready("bp");
    bus.in_vec    = 32'h0000_0080;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("bp latency", 32'(lat), 32'd32);
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'h0000_0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp%0d hold", c),
            32'({bus.out_valid, bus.out_idx, bus.out_err_zero, bus.out_err_multi}),
            32'({1'b1, 5'd7, 1'b0, 1'b0}));
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp handshake valid", 32'(bus.out_valid), 32'd0);
    check("bp bubble in_ready", 32'(bus.in_ready), 32'd1);
    check("bp idx retained", 32'(bus.out_idx), 32'd7);
    tick();
    bus.in_valid = 1'b0;
    check("bp second accepted", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("bp2 latency", 32'(lat), 32'd32);
    check("bp2 idx", 32'(bus.out_idx), 32'd0);
    check("bp2 errs", 32'({bus.out_err_zero, bus.out_err_multi}), 32'd0);
    tick();

    // Reset in cycle 15 of the scan discards the vector.
    wait_ready("mid");
    bus.in_vec   = 32'h0001_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 14; c++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    check("mid reset out_idx", 32'(bus.out_idx), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    check("mid discarded", 32'(seen), 32'd0);
    run_vec(32'h0000_0020, 5'd5, 1'b0, 1'b0, "after mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/onehot_index_decoder.md
Name: onehot_index_decoder

Overview:
- Sequential decoder that takes a 32-bit one-hot vector, as produced by the team's priority encoder, and recovers the 5-bit binary index of the set bit.
- Scans the captured vector one bit per cycle, MSB first, the same scan order the encoder uses.
- Flags vectors with no bit set or with more than one bit set.
- Sits downstream of the encoder; uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, width of the one-hot input vector.
- IDX_W, 5, index width; must equal clog2(WIDTH). Compile-time check.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block is IDLE and can accept a vector.
- in_vec  in  WIDTH  one-hot vector to decode.
- out_valid  out  1  result is valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  decoded index.
- out_err_zero  out  1  captured vector was all zeros.
- out_err_multi  out  1  captured vector had two or more bits set.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state <- IDLE; scan counter <- WIDTH-1; hit count <- 0; shadow vector <- 0.
  - out_valid, out_idx, out_err_zero, out_err_multi <- 0.
  - Takes priority over all other activity, including mid-scan; any in-flight vector is discarded.
- in_ready = (state == IDLE), decoded from the registered state. It is 1 in the first cycle after reset is released.
- IDLE:
  - Accept on in_valid && in_ready.
  - At that edge: shadow <- in_vec; counter <- WIDTH-1; hit count <- 0; state <- SCAN.
  - in_vec is not sampled at any other time.
- SCAN (exactly WIDTH cycles, independent of data, so latency is fixed):
  - Each cycle examines shadow[counter].
  - If the bit is set and hit count is 0, record idx <- counter.
  - If the bit is set, hit count increments, saturating at 2 (2-bit field).
  - When counter == 0: the last bit is processed; state <- DONE; out_valid <- 1.
  - Outputs load at the same edge: out_idx <- recorded idx, or 0 if no hit.
  - out_err_zero <- (hit count final == 0).
  - out_err_multi <- (hit count final >= 2).
  - Final hit count includes bit 0.
  - Otherwise the counter decrements. The counter never wraps: its decrement is gated by counter != 0.
- Latency: accept at edge E; out_valid is high after edge E+WIDTH (32 cycles).
- DONE:
  - out_valid, out_idx and the error flags are held stable until out_valid && out_ready.
  - At that edge: out_valid <- 0; state <- IDLE. in_ready is 1 in the following cycle, giving a one-cycle bubble with no same-cycle re-accept.
  - out_idx and the flags retain their last values after the handshake.
- Multi-hot input: out_idx is the highest set bit, matching encoder priority, and out_err_multi = 1.
- Zero input: out_idx = 0 and out_err_zero = 1; the index is meaningless in this case.
- out_err_zero and out_err_multi are never both 1.
- in_valid during SCAN or DONE is ignored (in_ready = 0). The upstream block must hold it under valid/ready rules.
- out_ready while out_valid = 0 has no effect.

Decomposition:
- Shared package holds:
  - the WIDTH/IDX_W constants;
  - the state enumeration IDLE=0, SCAN=1, DONE=2 (2-bit encoding);
  - the hit-count saturation constant (2).
- Single flat module: scan counter, hit counter, shadow register and FSM are tightly coupled. No sub-module.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles with in_valid=1 and in_vec=32'hFFFF_FFFF.
  - Required: out_valid=0 and all outputs 0 throughout.
  - Required: in_ready=1 in the first cycle after rst=1.
- Single-bit decode: apply in_vec=32'h0000_0400 with out_ready=1.
  - Required: out_valid rises exactly 32 cycles after the accept edge, with out_idx=10 and both error flags 0.
  - Sweep all 32 one-hot values; each must give out_idx equal to its bit position.
- Multi-hot input: apply in_vec=32'h8000_0001.
  - Required: out_idx=31, out_err_multi=1, out_err_zero=0.
  - Then apply 32'h0000_0003. Required: out_idx=1, out_err_multi=1.
- Zero input: apply in_vec=0.
  - Required: out_idx=0, out_err_zero=1, out_err_multi=0, latency still 32.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: outputs stable and in_ready=0 while stalled; a new in_valid with in_vec=32'h1 is not accepted.
  - Release out_ready. Required: in_ready=1 the next cycle; the second vector yields out_idx=0, no errors.
- Reset mid-scan: accept 32'h0001_0000 and drive rst=0 at cycle 15 of SCAN.
  - Required: out_valid never rises for that vector.
  - After release, a new vector 32'h0000_0020 yields out_idx=5 after 32 cycles.
